// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and width defaults for the program loader
package loader_pkg;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;
    localparam int NIB_W      = 4;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HI     = 3'd1,
        LO     = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4,
        CHK_HI = 3'd5,
        CHK_LO = 3'd6
    } state_t;
endpackage

// File: rtl/nib_packer.sv
// nib_packer: holds the high/low nibble registers and presents them as one byte
module nib_packer
    import loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_hi,
    input  logic              load_lo,
    input  logic [NIB_W-1:0]  nib,
    output logic [DATA_W-1:0] data
);
    logic [NIB_W-1:0] hi, lo;
    // capture each half of the byte as it is accepted
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            hi <= load_hi ? nib : hi;
            lo <= load_lo ? nib : lo;
        end
    assign data = {hi, lo};
endmodule

// File: rtl/prog_loader.sv
// prog_loader: packs a nibble stream into program bytes and writes them to ROM from address 0
// Optional checksum byte after the payload: define LOADER_CHECKSUM_EN.
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] len,
    input  logic              nib_valid,
    input  logic [NIB_W-1:0]  nib_data,
    output logic              nib_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              chk_err
);
    if (DATA_W != 2 * NIB_W) begin : g_bad_data_w
        $error("prog_loader: DATA_W must be exactly two nibbles");
    end

    state_t state, state_nx;
    logic [ADDR_W-1:0] addr, len_q;
    logic last, go;

    // addr equals the number of bytes already written, so the len-th byte is at len-1 (len=0 wraps to full depth)
    assign last = addr == len_q - ADDR_W'(1);
    assign go   = state == IDLE && start && !abort;

    nib_packer #(.DATA_W(DATA_W)) u_packer (
        .clock   (clock),
        .reset   (reset),
        .load_hi (nib_valid && (state == HI || state == CHK_HI)),
        .load_lo (nib_valid && state == LO),
        .nib     (nib_data),
        .data    (mem_wdata)
    );

    // state register
    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    // next state and per-state outputs; abort overrides everything outside IDLE
    always_comb begin
        state_nx  = state;
        nib_ready = 1'b0;
        mem_we    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  state_nx = go ? HI : IDLE;
            HI: begin
                nib_ready = 1'b1;
                state_nx  = nib_valid ? LO : HI;
            end
            LO: begin
                nib_ready = 1'b1;
                state_nx  = nib_valid ? WRITE : LO;
            end
            WRITE: begin
                mem_we = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                state_nx = last ? CHK_HI : HI;
`else
                state_nx = last ? DONE : HI;
`endif
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK_HI: begin
                nib_ready = 1'b1;
                state_nx  = nib_valid ? CHK_LO : CHK_HI;
            end
            CHK_LO: begin
                nib_ready = 1'b1;
                state_nx  = nib_valid ? DONE : CHK_LO;
            end
`endif
            default: state_nx = IDLE;
        endcase
        if (state != IDLE && abort) begin
            state_nx = IDLE;
            mem_we   = 1'b0;
            done     = 1'b0;
        end
    end

    assign busy     = state != IDLE;
    assign cpu_hold = busy;
    assign mem_addr = addr;

    // load length latch and write address counter
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            addr  <= '0;
            len_q <= '0;
        end else begin
            len_q <= go ? len : len_q;
            addr  <= go ? '0 : mem_we ? addr + ADDR_W'(1) : addr;
        end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum, chk_sum;
    assign chk_sum = csum + {mem_wdata[DATA_W-1:NIB_W], nib_data};
    // running sum of written bytes; the trailing byte must bring it to zero
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            csum    <= '0;
            chk_err <= 1'b0;
        end else begin
            csum    <= go ? '0 : mem_we ? csum + mem_wdata : csum;
            chk_err <= go ? 1'b0
                     : (state == CHK_LO && nib_valid && !abort) ? chk_sum != '0
                     : chk_err;
        end
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized loads checked against a byte-list reference model
module tb_prog_loader;
    logic        clock = 1'b0;
    logic        reset, start, abort, nib_valid;
    logic [11:0] len;
    logic [3:0]  nib_data;
    logic        nib_ready, mem_we, cpu_hold, busy, done, chk_err;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    bit          clk_en = 1'b0;
    int          checks = 0, failures = 0, cyc = 0;
    int          done_cnt = 0, done_cyc = 0, last_we = 0;
    logic [11:0] got_a[$];
    logic [7:0]  got_d[$];

    prog_loader dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .len(len),
        .nib_valid(nib_valid), .nib_data(nib_data), .nib_ready(nib_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .chk_err(chk_err)
    );

    always #5 if (clk_en) clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // record every write and done pulse seen on the memory side
    always @(negedge clock) begin
        if (mem_we) begin
            got_a.push_back(mem_addr);
            got_d.push_back(mem_wdata);
            last_we = cyc;
            chk("ready_in_write", {31'd0, nib_ready}, 32'd0);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic feed(input logic [3:0] nq[$], input int gap);
        int i = 0;
        int n = 0;
        bit hold = 1'b0;
        while (i < nq.size() && n < 40000) begin
            @(negedge clock);
            n++;
            if (!hold) nib_valid = ($urandom_range(0, 99) >= gap);
            nib_data = nib_valid ? nq[i] : 4'($urandom);
            hold = nib_valid && !nib_ready;
            if (nib_valid && nib_ready) i++;
        end
        chk("feed_bound", i, nq.size());
        @(negedge clock);
        nib_valid = 1'b0;
    endtask

    task automatic clear_mon();
        got_a.delete();
        got_d.delete();
        done_cnt = 0;
    endtask

    task automatic run_load(input logic [7:0] b[$], input logic [11:0] lv, input int gap, input bit bad);
        logic [3:0] nq[$];
        logic [7:0] sum = 8'd0;
        int w = 0;
        clear_mon();
        foreach (b[i]) begin
            nq.push_back(b[i] >> 4);
            nq.push_back(b[i] % 16);
            sum += b[i];
        end
`ifdef LOADER_CHECKSUM_EN
        sum = 8'd0 - sum + {7'd0, bad};
        nq.push_back(sum >> 4);
        nq.push_back(sum % 16);
`endif
        @(negedge clock);
        start = 1'b1;
        len = lv;
        @(negedge clock);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        feed(nq, gap);
        while (done_cnt == 0 && w < 50) begin
            @(negedge clock);
            w++;
        end
        chk("done_seen", done_cnt, 1);
        @(negedge clock);
        chk("hold_after_done", {31'd0, cpu_hold}, 32'd0);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        @(negedge clock);
        chk("done_once", done_cnt, 1);
        chk("n_writes", got_a.size(), b.size());
        for (int i = 0; i < b.size() && i < got_a.size(); i++) begin
            chk("wr_addr", got_a[i], i);
            chk("wr_data", got_d[i], b[i]);
        end
`ifndef LOADER_CHECKSUM_EN
        chk("done_latency", done_cyc, last_we + 1);
`endif
    endtask

    initial begin
        logic [7:0] b[$];
        reset = 1'b0; start = 1'b0; abort = 1'b0; len = '0;
        nib_valid = 1'b0; nib_data = '0;
        #1;
        chk("rst_ready", {31'd0, nib_ready}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", {20'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_chk_err", {31'd0, chk_err}, 32'd0);
        clk_en = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        // directed: A,1,2,B,F,0
        b = '{8'hA1, 8'h2B, 8'hF0};
        run_load(b, 12'd3, 0, 1'b0);
        chk("chk_err_clean", {31'd0, chk_err}, 32'd0);
        // random bytes with random valid gaps
        b.delete();
        repeat (9) b.push_back(8'($urandom));
        run_load(b, 12'd9, 50, 1'b0);
        // start+abort in IDLE stays idle
        @(negedge clock);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", {31'd0, busy}, 32'd0);
        // full-depth load with a stray start mid-way
        b.delete();
        repeat (4096) b.push_back(8'($urandom));
        fork
            run_load(b, 12'd0, 0, 1'b0);
            begin
                repeat (3000) @(negedge clock);
                start = 1'b1;
                len = 12'd5;
                @(negedge clock);
                start = 1'b0;
            end
        join
        // abort after three nibbles of a 4-byte load
        clear_mon();
        @(negedge clock);
        start = 1'b1;
        len = 12'd4;
        @(negedge clock);
        start = 1'b0;
        feed('{4'hA, 4'hB, 4'hC}, 0);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_hold", {31'd0, cpu_hold}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clock);
        chk("abort_writes", got_a.size(), 1);
        if (got_a.size() > 0) begin
            chk("abort_addr", got_a[0], 0);
            chk("abort_data", got_d[0], 8'hAB);
        end
        chk("abort_no_done", done_cnt, 0);
        // reload after abort starts again at address 0
        b.delete();
        repeat (2) b.push_back(8'($urandom));
        run_load(b, 12'd2, 30, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        b = '{8'h10, 8'h20};
        run_load(b, 12'd2, 0, 1'b0);
        chk("chk_good", {31'd0, chk_err}, 32'd0);
        run_load(b, 12'd2, 0, 1'b1);
        chk("chk_bad", {31'd0, chk_err}, 32'd1);
        repeat (5) @(negedge clock);
        chk("chk_sticky", {31'd0, chk_err}, 32'd1);
        start = 1'b1;
        len = 12'd1;
        @(negedge clock);
        start = 1'b0;
        chk("chk_cleared", {31'd0, chk_err}, 32'd0);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
`else
        chk("chk_err_tied", {31'd0, chk_err}, 32'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
